module_debouncer_multi: RTL and testbench
=========================================

Name: module_debouncer_multi

Overview:
Parametrised N-channel debouncer for raw pushbutton and switch inputs. Each channel has its own input synchroniser and stability counter. Each channel outputs a clean level plus one-cycle rise and fall strobes. It sits between the board pins and the control FSMs, which consume the strobes directly instead of doing their own edge detection.

Parameters:
N_CH, 4, number of independent channels (>=1)
STABLE_CYCLES, 8, consecutive clk cycles a new synchronised value must hold before it is accepted (>=1)
SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2)
RST_LEVEL, 1'b0, level loaded into the synchronisers and level_o on reset

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-low reset
bt_i  input  N_CH  raw asynchronous button/switch inputs, one bit per channel
level_o  output  N_CH  debounced level per channel
rise_o  output  N_CH  one-cycle strobe: channel level_o went 0->1 this cycle
fall_o  output  N_CH  one-cycle strobe: channel level_o went 1->0 this cycle
any_change_o  output  1  OR of rise_o and fall_o over all channels

Behaviour:
- Reset (rst_i=0, asynchronous):
  - every synchroniser flop = RST_LEVEL;
  - level_o = {N_CH{RST_LEVEL}};
  - counters = 0;
  - rise_o, fall_o, any_change_o = 0.
- Reset release: since the synchronisers are preloaded with RST_LEVEL, release produces no spurious strobe.
- Synchroniser: per channel, a SYNC_STAGES-deep chain; s = output of the last stage. Nothing downstream reads bt_i directly.
- Counter: per channel, width $clog2(STABLE_CYCLES+1). Each rising edge:
  - s == level_o[c]: counter <= 0; outputs hold.
  - s != level_o[c] and counter < STABLE_CYCLES-1: counter <= counter+1.
  - s != level_o[c] and counter == STABLE_CYCLES-1: level_o[c] <= s, counter <= 0, and rise_o[c] <= s (or fall_o[c] <= ~s).
- Bounce rejection: any single cycle with s == level_o restarts qualification from zero. Pulses and glitches shorter than STABLE_CYCLES cycles (after synchronisation) never reach level_o.
- Latency: bt_i changes and then stays stable. Count the first rising edge that samples the new value as edge 1. level_o, plus the matching strobe, updates on edge SYNC_STAGES+STABLE_CYCLES (edge 10 with defaults).
- Strobes:
  - registered, high for exactly one cycle, in the same cycle level_o changes;
  - rise_o[c] and fall_o[c] are never high together;
  - minimum spacing between strobes on one channel is STABLE_CYCLES cycles.
- any_change_o: registered in the same cycle as the strobes. It is high if any channel strobes.
- Channels are fully independent. Simultaneous transitions on several channels give simultaneous strobes with no arbitration.
- STABLE_CYCLES=1: the output follows s with one register of delay. The no-strobe-on-glitch rule is then limited to what the synchroniser filters.
- Reset asserted mid-count or mid-strobe: everything returns to its reset values immediately. No strobe is emitted for the interrupted change.
- No wrap-around: the counter never exceeds STABLE_CYCLES-1.

Test Plan:
1. Reset/idle. Defaults, rst_i low for 3 cycles, bt_i=4'b0000, release -> level_o=0000; no strobes during or after release for 20 cycles.
2. Clean press. bt_i[0] 0->1 and held -> level_o[0]=1 and rise_o[0]=1 for exactly one cycle on edge 10; any_change_o=1 in the same cycle; other channels unchanged.
3. Bouncy press, 10 ns clk. On ch1, toggle bt_i with high/low widths of 5, 7, 10, 15, 10, 20 ns, then hold 1 for 1000 ns -> no strobe during bouncing. Exactly one rise_o[1], 10 cycles after the last 0->1 edge; exactly one fall_o[1] after release plus 10 cycles.
4. Short glitch. Ch2 level 0, bt_i[2] high for 7 clk cycles then low -> level_o[2] stays 0; rise_o[2] never asserts.
5. Simultaneous channels. bt_i 0000->1111 on one edge -> rise_o=1111 on the same cycle, one cycle wide. Then 1111->1010 -> fall_o=0101 only.
6. Reset mid-operation. Press ch3, assert rst_i after 5 cycles of qualification -> level_o[3]=RST_LEVEL immediately, no rise_o[3]. After release with bt_i[3] still 1, rise_o[3] occurs 10 edges later. Repeat with RST_LEVEL=1.

Source files
------------

// File: rtl/module_debouncer_multi.sv
// N-channel debouncer: per-channel synchroniser and stability counter, with a
// registered clean level, one-cycle rise/fall strobes and a global change flag.
module module_debouncer_multi #(
    parameter int   N_CH          = 4,
    parameter int   STABLE_CYCLES = 8,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RST_LEVEL     = 1'b0
) (
    input  logic            clk,
    input  logic            rst_i,
    input  logic [N_CH-1:0] bt_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic            any_change_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  sync_s;
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [N_CH-1:0]  level_q, level_d;
    logic [N_CH-1:0]  rise_q,  rise_d;
    logic [N_CH-1:0]  fall_q,  fall_d;
    logic             any_q,   any_d;

    // Preloading RST_LEVEL keeps reset release from looking like an input edge.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {N_CH{RST_LEVEL}};
            end
        end else begin
            sync_q[0] <= bt_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int c = 0; c < N_CH; c++) begin
            cnt_d[c] = '0;
            if (sync_s[c] != level_q[c]) begin
                if (cnt_q[c] == CNT_LAST) begin
                    level_d[c] = sync_s[c];
                    rise_d[c]  = sync_s[c];
                    fall_d[c]  = ~sync_s[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
            end
            level_q <= {N_CH{RST_LEVEL}};
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
        end
    end

    assign level_o      = level_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign any_change_o = any_q;

endmodule

// File: tb/tb_module_debouncer_multi.sv
// Bench for module_debouncer_multi: two configurations driven by one stimulus,
// compared every cycle against a window-based reference model.
module tb_module_debouncer_multi;

    localparam int   SS0 = 2;
    localparam int   SC0 = 8;
    localparam logic RL0 = 1'b0;
    localparam int   SS1 = 3;
    localparam int   SC1 = 3;
    localparam logic RL1 = 1'b1;

    logic       clk;
    logic       rst_i;
    logic [3:0] bt_i;
    logic [3:0] lvl0, rise0, fall0;
    logic [3:0] lvl1, rise1, fall1;
    logic       any0, any1;

    int n_vec = 0;
    int n_err = 0;

    module_debouncer_multi #(
        .N_CH(4), .STABLE_CYCLES(SC0), .SYNC_STAGES(SS0), .RST_LEVEL(RL0)
    ) dut0 (
        .clk(clk), .rst_i(rst_i), .bt_i(bt_i),
        .level_o(lvl0), .rise_o(rise0), .fall_o(fall0), .any_change_o(any0)
    );

    module_debouncer_multi #(
        .N_CH(4), .STABLE_CYCLES(SC1), .SYNC_STAGES(SS1), .RST_LEVEL(RL1)
    ) dut1 (
        .clk(clk), .rst_i(rst_i), .bt_i(bt_i),
        .level_o(lvl1), .rise_o(rise1), .fall_o(fall1), .any_change_o(any1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ss(input int d);
        return (d == 0) ? SS0 : SS1;
    endfunction
    function automatic int sc(input int d);
        return (d == 0) ? SC0 : SC1;
    endfunction
    function automatic logic rl(input int d);
        return (d == 0) ? RL0 : RL1;
    endfunction

    // Reference: level flips when the last STABLE synchronised samples since
    // reset all differ from it; the synchronised sample is bt delayed SYNC edges.
    logic [3:0] hb [2][32];
    logic [3:0] hs [2][32];
    int         ne [2];
    logic [3:0] exp_lvl [2];
    logic [3:0] exp_rise [2];
    logic [3:0] exp_fall [2];

    task automatic model_reset(input int d);
        ne[d]       = 0;
        exp_lvl[d]  = {4{rl(d)}};
        exp_rise[d] = '0;
        exp_fall[d] = '0;
    endtask

    task automatic model_step(input int d, input logic [3:0] b);
        int         e;
        logic [3:0] s;
        logic       ok;
        ne[d]++;
        e = ne[d];
        s = (e <= ss(d)) ? {4{rl(d)}} : hb[d][(e - ss(d)) % 32];
        hs[d][e % 32] = s;
        hb[d][e % 32] = b;
        exp_rise[d] = '0;
        exp_fall[d] = '0;
        if (e >= sc(d)) begin
            for (int c = 0; c < 4; c++) begin
                ok = 1'b1;
                for (int k = 0; k < sc(d); k++) begin
                    if (hs[d][(e - k) % 32][c] == exp_lvl[d][c]) ok = 1'b0;
                end
                if (ok) begin
                    exp_lvl[d][c] = ~exp_lvl[d][c];
                    if (exp_lvl[d][c]) exp_rise[d][c] = 1'b1;
                    else               exp_fall[d][c] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) model_reset(d);
        forever begin
            @(posedge clk or negedge rst_i);
            for (int d = 0; d < 2; d++) begin
                if (!rst_i) model_reset(d);
                else        model_step(d, bt_i);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk_eq("level0", 32'(lvl0),  32'(exp_lvl[0]));
            chk_eq("rise0",  32'(rise0), 32'(exp_rise[0]));
            chk_eq("fall0",  32'(fall0), 32'(exp_fall[0]));
            chk_eq("any0",   32'(any0),  32'(|(exp_rise[0] | exp_fall[0])));
            chk_eq("level1", 32'(lvl1),  32'(exp_lvl[1]));
            chk_eq("rise1",  32'(rise1), 32'(exp_rise[1]));
            chk_eq("fall1",  32'(fall1), 32'(exp_fall[1]));
            chk_eq("any1",   32'(any1),  32'(|(exp_rise[1] | exp_fall[1])));
        end
    end

    int a0cnt = 0, r1cnt = 0, f1cnt = 0, r2cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (any0)     a0cnt++;
            if (rise0[1]) r1cnt++;
            if (fall0[1]) f1cnt++;
            if (rise0[2]) r2cnt++;
        end
    end

    task automatic measure(input int ch, output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (n0 == 0 && rise0[ch]) n0 = i;
            if (n1 == 0 && rise1[ch]) n1 = i;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, n1, r, k;
        rst_i = 1'b0;
        bt_i  = 4'b0000;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        a0cnt = 0;
        settle(20);
        chk_eq("idle_any0", 32'(a0cnt), 32'd0);
        chk_eq("idle_lvl0", 32'(lvl0), 32'h0);

        // Clean press on ch0
        bt_i[0] = 1'b1;
        measure(0, n0, n1);
        chk_eq("lat_rise0", 32'(n0), 32'(SS0 + SC0));
        chk_eq("lat_rise1", 32'(n1), 32'(SS1 + SC1));

        // Bouncy press on ch1 (edges kept clear of the clock edge)
        r1cnt = 0;
        f1cnt = 0;
        bt_i[1] = 1'b1; #5;
        bt_i[1] = 1'b0; #7;
        bt_i[1] = 1'b1; #10;
        bt_i[1] = 1'b0; #15;
        bt_i[1] = 1'b1; #10;
        bt_i[1] = 1'b0; #20;
        bt_i[1] = 1'b1; #1000;
        bt_i[1] = 1'b0; #300;
        chk_eq("bounce_rises", 32'(r1cnt), 32'd1);
        chk_eq("bounce_falls", 32'(f1cnt), 32'd1);

        // Short glitch on ch2
        settle(1);
        r2cnt = 0;
        bt_i[2] = 1'b1;
        settle(7);
        bt_i[2] = 1'b0;
        settle(30);
        chk_eq("glitch_rises", 32'(r2cnt), 32'd0);
        chk_eq("glitch_lvl", 32'(lvl0[2]), 32'd0);

        // Simultaneous channels
        bt_i = 4'b0000;
        settle(30);
        bt_i = 4'b1111;
        settle(SS0 + SC0 - 1);
        chk_eq("sim_early", 32'(rise0), 32'h0);
        settle(1);
        chk_eq("sim_rise", 32'(rise0), 32'hF);
        chk_eq("sim_any", 32'(any0), 32'd1);
        settle(1);
        chk_eq("sim_width", 32'(rise0), 32'h0);
        settle(20);
        bt_i = 4'b1010;
        settle(SS0 + SC0);
        chk_eq("sim_fall", 32'(fall0), 32'h5);
        chk_eq("sim_fall_rise", 32'(rise0), 32'h0);

        // Reset in the middle of qualification on ch3
        bt_i = 4'b0000;
        settle(30);
        bt_i[3] = 1'b1;
        repeat (SS0 + 5) @(posedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        chk_eq("rst_lvl0", 32'(lvl0), 32'h0);
        chk_eq("rst_rise0", 32'(rise0), 32'h0);
        chk_eq("rst_any0", 32'(any0), 32'd0);
        chk_eq("rst_lvl1", 32'(lvl1), 32'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        measure(3, n0, n1);
        chk_eq("rst_relat0", 32'(n0), 32'(SS0 + SC0));
        chk_eq("rst_relat1", 32'(n1), 32'd0);

        // Randomised traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #($urandom_range(1, 4));
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                bt_i = 4'($urandom);
            end else if (r < 3) begin
                k = int'($urandom_range(0, 3));
                bt_i[k] = ~bt_i[k];
            end
            if ($urandom_range(0, 599) == 0) begin
                rst_i = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst_i = 1'b1;
            end
        end

        settle(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
